usb_tx_line: RTL and testbench

- Parametrised outbound line encoder for the USB host datapath.
- Accepts one complete packet (PID/payload/CRC already assembled by the CRC encoder) as a parallel word plus a bit length.
- Prepends SYNC, serialises LSB first, and bit-stuffs with a configurable run length.
- NRZI-encodes, drives dp/dm with an output enable, and appends a configurable EOP.
- Replaces the fixed-width stuffer → nrzi → dpdm outbound chain with a single handshaked block.

---
 rtl/usb_tx_line_if.sv | 26 ++
 rtl/usb_tx_line.sv | 191 +++++++++++++++++++
 tb/tb_usb_tx_line.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_line_if.sv
// Packet handshake between the CRC encoder and the USB line encoder.
// The master offers a complete packet word plus its bit length; the slave
// (usb_tx_line) raises pkt_ready while it is free to take one.
interface usb_tx_line_if #(
    parameter int PKT_W = 99,
    parameter int LEN_W = $clog2(PKT_W + 1)
);
    logic [PKT_W-1:0] pkt_in;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_valid;
    logic             pkt_ready;

    modport master (
        output pkt_in,
        output pkt_len,
        output pkt_valid,
        input  pkt_ready
    );

    modport slave (
        input  pkt_in,
        input  pkt_len,
        input  pkt_valid,
        output pkt_ready
    );
endinterface

// File: rtl/usb_tx_line.sv
// USB outbound line encoder: takes one assembled packet, sends SYNC, the
// packet bits LSB first with bit stuffing, NRZI-codes them onto dp/dm and
// closes with SE0 cycles plus one J cycle.
// Optional feature macro: USB_TX_STUFF_STATS_EN adds the stuff_count output.
module usb_tx_line #(
    parameter int PKT_W     = 99,
    parameter int LEN_W     = $clog2(PKT_W + 1),
    parameter int STUFF_RUN = 6,
    parameter int EOP_SE0   = 2
) (
    input  logic           clk,
    input  logic           rst_b,
    usb_tx_line_if.slave   pktIf,
    output logic           dp_w,
    output logic           dm_w,
    output logic           line_oe,
    output logic           busy,
    output logic           done
`ifdef USB_TX_STUFF_STATS_EN
    ,
    output logic [7:0]     stuff_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [PKT_W-1:0] r_data;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [3:0]       r_run;
    logic [2:0]       r_cnt;
    logic             r_level;
    logic             r_done;

    logic             w_accept;
    logic             w_drive;
    logic             w_se0;
    logic             w_bit;
    logic             w_lineLevel;
    logic [3:0]       w_runAfter;
    logic [LEN_W-1:0] w_lenClamped;

    // Oversized lengths are limited to the word width so idx can never run past the data.
    assign w_lenClamped = (pktIf.pkt_len > LEN_W'(PKT_W)) ? LEN_W'(PKT_W) : pktIf.pkt_len;

    // r_data shifts right as bits go out, so the current data bit is always bit 0.
    assign w_runAfter  = r_data[0] ? (r_run + 4'd1) : 4'd0;
    assign w_lineLevel = w_bit ? r_level : ~r_level;

    // State register; reset aborts any packet instantly with no EOP.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the line drive for the bit being sent this cycle.
    always_comb begin
        w_nextState     = r_state;
        w_accept        = 1'b0;
        w_drive         = 1'b0;
        w_se0           = 1'b0;
        w_bit           = 1'b1;
        pktIf.pkt_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                pktIf.pkt_ready = 1'b1;
                if (pktIf.pkt_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_SYNC;
                end
            end
            ST_SYNC: begin
                w_drive = 1'b1;
                w_bit   = (r_cnt == 3'd7);
                if (r_cnt == 3'd7) begin
                    w_nextState = (r_len == '0) ? ST_EOP_SE0 : ST_DATA;
                end
            end
            ST_DATA: begin
                w_drive = 1'b1;
                w_bit   = r_data[0];
                if (w_runAfter == 4'(STUFF_RUN)) begin
                    w_nextState = ST_STUFF;
                end else if ((r_idx + LEN_W'(1)) == r_len) begin
                    w_nextState = ST_EOP_SE0;
                end
            end
            ST_STUFF: begin
                w_drive     = 1'b1;
                w_bit       = 1'b0;
                w_nextState = (r_idx == r_len) ? ST_EOP_SE0 : ST_DATA;
            end
            ST_EOP_SE0: begin
                w_se0 = 1'b1;
                if (r_cnt == 3'(EOP_SE0 - 1)) begin
                    w_nextState = ST_EOP_J;
                end
            end
            ST_EOP_J: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        dp_w    = w_drive ? w_lineLevel : ~w_se0;
        dm_w    = w_drive ? ~w_lineLevel : 1'b0;
        line_oe = (r_state != ST_IDLE);
        busy    = (r_state != ST_IDLE);
        done    = r_done;
    end

    // Datapath: packet latch, bit index, ones-run tracking, NRZI level and phase counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_data  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_run   <= 4'd0;
            r_cnt   <= 3'd0;
            r_level <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_EOP_J);
            if (w_drive) begin
                r_level <= w_lineLevel;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data  <= pktIf.pkt_in;
                        r_len   <= w_lenClamped;
                        r_idx   <= '0;
                        r_run   <= 4'd0;
                        r_cnt   <= 3'd0;
                        r_level <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_run <= 4'd1;
                    end
                end
                ST_DATA: begin
                    r_data <= r_data >> 1;
                    r_idx  <= r_idx + LEN_W'(1);
                    r_run  <= w_runAfter;
                end
                ST_STUFF: begin
                    r_run <= 4'd0;
                end
                ST_EOP_SE0: begin
                    r_cnt <= (r_cnt == 3'(EOP_SE0 - 1)) ? 3'd0 : (r_cnt + 3'd1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef USB_TX_STUFF_STATS_EN
    logic [7:0] r_stuffCount;

    // Per-packet stuffed-bit tally, saturating, kept after done until the next accept.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_stuffCount <= 8'd0;
        end else if (w_accept) begin
            r_stuffCount <= 8'd0;
        end else if ((r_state == ST_STUFF) && (r_stuffCount != 8'hFF)) begin
            r_stuffCount <= r_stuffCount + 8'd1;
        end
    end

    assign stuff_count = r_stuffCount;
`endif

endmodule

// File: tb/tb_usb_tx_line.sv
// Self-checking bench for usb_tx_line: hand-derived vectors for the key
// packets, a back-to-back pair, random packets against a bit-stream model,
// and a reset abort in the middle of the data phase.
module tb_usb_tx_line;

    localparam int PKT_W     = 99;
    localparam int LEN_W     = $clog2(PKT_W + 1);
    localparam int STUFF_RUN = 6;
    localparam int EOP_SE0   = 2;

    logic clk = 1'b0;
    logic rst_b;
    logic dp_w;
    logic dm_w;
    logic line_oe;
    logic busy;
    logic done;
`ifdef USB_TX_STUFF_STATS_EN
    logic [7:0] stuff_count;
`endif

    int nChecks = 0;
    int nFails  = 0;

    logic [1:0] expLine[$];
    int         expStuffs;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        int               len;
        int               expOe;
        logic [31:0]      expDp;
        int               expStuffs;
    } vec_t;

    vec_t vecs[4];

    usb_tx_line_if #(.PKT_W(PKT_W), .LEN_W(LEN_W)) pktIf ();

    usb_tx_line #(
        .PKT_W(PKT_W),
        .LEN_W(LEN_W),
        .STUFF_RUN(STUFF_RUN),
        .EOP_SE0(EOP_SE0)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .pktIf(pktIf.slave),
        .dp_w(dp_w),
        .dm_w(dm_w),
        .line_oe(line_oe),
        .busy(busy),
        .done(done)
`ifdef USB_TX_STUFF_STATS_EN
        ,
        .stuff_count(stuff_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // Reference: transmitted bit stream = SYNC + data with a 0 inserted after
    // every STUFF_RUN consecutive ones, then NRZI from J, then SE0s and one J.
    function automatic void buildModel(input logic [PKT_W-1:0] pkt, input int len);
        bit txBits[$];
        int ones;
        int n;
        bit level;
        n = (len > PKT_W) ? PKT_W : len;
        expLine.delete();
        expStuffs = 0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            txBits.push_back(i == 7);
            ones = (i == 7) ? ones + 1 : 0;
        end
        for (int i = 0; i < n; i++) begin
            txBits.push_back(pkt[i]);
            ones = pkt[i] ? ones + 1 : 0;
            if (ones == STUFF_RUN) begin
                txBits.push_back(1'b0);
                ones = 0;
                expStuffs++;
            end
        end
        level = 1'b1;
        foreach (txBits[i]) begin
            if (!txBits[i]) level = ~level;
            expLine.push_back({level, ~level});
        end
        for (int i = 0; i < EOP_SE0; i++) expLine.push_back(2'b00);
        expLine.push_back(2'b10);
    endfunction

    task automatic applyStimulus(input logic [PKT_W-1:0] pkt, input int len);
        pktIf.pkt_in    = pkt;
        pktIf.pkt_len   = LEN_W'(len);
        pktIf.pkt_valid = 1'b1;
    endtask

    // Called at a negedge with the packet already offered; returns at the done cycle.
    task automatic runPacket(input string name, input logic [PKT_W-1:0] pkt, input int len,
                             input bit nextValid, input logic [PKT_W-1:0] nextPkt, input int nextLen,
                             output logic [31:0] dpBits, output int oeCycles);
        int n;
        buildModel(pkt, len);
        dpBits   = '0;
        oeCycles = 0;
        checkOutput({name, " ready"}, 32'(pktIf.pkt_ready), 32'd1);
        @(negedge clk);
        pktIf.pkt_valid = nextValid;
        pktIf.pkt_in    = nextPkt;
        pktIf.pkt_len   = LEN_W'(nextLen);
        n = expLine.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("%s cyc%0d dp/dm/oe/busy/ready/done", name, i),
                        32'({dp_w, dm_w, line_oe, busy, pktIf.pkt_ready, done}),
                        32'({expLine[i], 1'b1, 1'b1, 1'b0, 1'b0}));
            if (i < 32) dpBits[i] = dp_w;
            if (line_oe) oeCycles++;
        end
        @(negedge clk);
        checkOutput({name, " done cycle"},
                    32'({dp_w, dm_w, line_oe, busy, pktIf.pkt_ready, done}), 32'b100011);
`ifdef USB_TX_STUFF_STATS_EN
        checkOutput({name, " stuff_count"}, 32'(stuff_count), 32'(expStuffs));
`endif
    endtask

    initial begin
        logic [31:0]      dpBits;
        int               oeCycles;
        logic [PKT_W-1:0] pkt;
        int               len;

        vecs[0] = '{PKT_W'(8'hA5), 8, 19, 32'h0004362A, 0};
        vecs[1] = '{PKT_W'(8'hFF), 8, 20, 32'h0009E02A, 1};
        vecs[2] = '{PKT_W'(5'h1F), 5, 17, 32'h0001202A, 1};
        vecs[3] = '{PKT_W'(0),     0, 11, 32'h0000042A, 0};

        rst_b           = 1'b0;
        pktIf.pkt_valid = 1'b0;
        pktIf.pkt_in    = '0;
        pktIf.pkt_len   = '0;
        #12;
        checkOutput("in reset", 32'({dp_w, dm_w, line_oe, busy, pktIf.pkt_ready, done}), 32'b100010);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle %0d", i),
                        32'({dp_w, dm_w, line_oe, busy, pktIf.pkt_ready, done}), 32'b100010);
        end

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].pkt, vecs[v].len);
            runPacket($sformatf("vec%0d", v), vecs[v].pkt, vecs[v].len, 1'b0, '0, 0, dpBits, oeCycles);
            checkOutput($sformatf("vec%0d dp pattern", v), dpBits, vecs[v].expDp);
            checkOutput($sformatf("vec%0d oe cycles", v), 32'(oeCycles), 32'(vecs[v].expOe));
`ifdef USB_TX_STUFF_STATS_EN
            checkOutput($sformatf("vec%0d stuff_count hold", v), 32'(stuff_count), 32'(vecs[v].expStuffs));
`endif
            @(negedge clk);
            checkOutput($sformatf("vec%0d after done", v), 32'({line_oe, done}), 32'b00);
        end

        applyStimulus(PKT_W'(8'hA5), 8);
        runPacket("b2b first", PKT_W'(8'hA5), 8, 1'b1, '0, 0, dpBits, oeCycles);
        runPacket("b2b second", '0, 0, 1'b0, '0, 0, dpBits, oeCycles);
        checkOutput("b2b second oe cycles", 32'(oeCycles), 32'd11);
        checkOutput("b2b second dp pattern", dpBits, 32'h0000042A);
        @(negedge clk);
        checkOutput("b2b after done", 32'({line_oe, done}), 32'b00);

        for (int r = 0; r < 25; r++) begin
            for (int b = 0; b < PKT_W; b++) pkt[b] = ($urandom_range(0, 3) != 0);
            len = $urandom_range(0, PKT_W + 8);
            applyStimulus(pkt, len);
            runPacket($sformatf("rand%0d len%0d", r, len), pkt, len, 1'b0, '0, 0, dpBits, oeCycles);
            @(negedge clk);
            checkOutput($sformatf("rand%0d after done", r), 32'({line_oe, done}), 32'b00);
        end

        applyStimulus(PKT_W'(8'hFF), 8);
        @(negedge clk);
        pktIf.pkt_valid = 1'b0;
        repeat (11) @(negedge clk);
        checkOutput("abort in data", 32'(line_oe), 32'd1);
        rst_b = 1'b0;
        #1;
        checkOutput("abort async", 32'({dp_w, dm_w, line_oe, busy, pktIf.pkt_ready, done}), 32'b100010);
`ifdef USB_TX_STUFF_STATS_EN
        checkOutput("abort stuff_count", 32'(stuff_count), 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post abort %0d", i),
                        32'({dp_w, dm_w, line_oe, busy, pktIf.pkt_ready, done}), 32'b100010);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
